sad_phase_matcher: RTL and testbench

//  Phase-scan matcher: for each phase p in 0..P, sums |CAP[i]-REF[i+p]| over i=0..LEN-1-p, both read from the waveform SRAM.

---
 rtl/coinc_pkg.sv | 29 ++
 rtl/sad_accumulator.sv | 53 +++++
 rtl/sad_phase_matcher.sv | 225 ++++++++++++++++++++++
 tb/tb_sad_phase_matcher.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coinc_pkg.sv
// Shared definitions for the SAD phase matcher: FSM state encoding,
// default SRAM record base addresses and a constant-evaluable clog2.
package coinc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_CAP   = 3'd1,
    WAIT_CAP = 3'd2,
    RD_REF   = 3'd3,
    WAIT_REF = 3'd4,
    ACC      = 3'd5,
    EMIT     = 3'd6,
    FIN      = 3'd7
  } state_e;

  localparam int unsigned CAP_BASE_DEF = 32'd0;
  localparam int unsigned REF_BASE_DEF = 32'd262144;

  // Smallest n with 2**n >= v; usable in parameter expressions.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned n;
    n = 32'd0;
    while ((64'd1 << n) < 64'(v)) begin
      n = n + 32'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/sad_accumulator.sv
// Accumulates |a-b| into a registered sum. Clear has priority over enable.
module sad_accumulator
  import coinc_pkg::*;
#(
  parameter int DW = 16,
  parameter int SW = 29
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [SW-1:0] sum
);

  logic [DW-1:0] diff_s;
  logic [SW-1:0] sum_d;
  logic [SW-1:0] sum_q;

  // Unsigned absolute difference of the two samples.
  always_comb begin
    if (a > b) begin
      diff_s = a - b;
    end else begin
      diff_s = b - a;
    end
  end

  // Next accumulated value: clear, add, or hold.
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (enable) begin
      sum_d = sum_q + SW'(diff_s);
    end else begin
      sum_d = sum_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/sad_phase_matcher.sv
// Phase-scan SAD matcher: for each phase p walks the captured and reference
// records in SRAM, one sample per 2*RD_LAT+3 cycles, streams (phase, SAD)
// results with valid/ready and tracks the minimum-SAD phase.
module sad_phase_matcher
  import coinc_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 20,
  parameter int LEN       = 8192,
  parameter int MAX_PHASE = 4095,
  parameter int CAP_BASE  = int'(CAP_BASE_DEF),
  parameter int REF_BASE  = int'(REF_BASE_DEF),
  parameter int RD_LAT    = 2,
  parameter int SW        = DW + int'(clog2_f(LEN)),
  parameter int PW        = int'(clog2_f(MAX_PHASE + 1))
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          ABORT,
  input  logic [PW-1:0] PHASE_LIMIT,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_RD,
  input  logic [DW-1:0] MEM_DATA,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic [PW-1:0] RES_PHASE,
  output logic [SW-1:0] RES_SUM,
  output logic [PW-1:0] BEST_PHASE,
  output logic [SW-1:0] BEST_SUM,
  output logic          BUSY,
  output logic          DONE
);

  localparam int IW = int'(clog2_f(LEN));
  localparam int WW = int'(clog2_f(RD_LAT + 1));

  state_e        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] plim_q, plim_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [SW-1:0] best_sum_q, best_sum_d;
  logic [PW-1:0] best_phase_q, best_phase_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          acc_clr_s;
  logic          acc_en_s;
  logic [SW-1:0] acc_sum_s;
  logic [AW-1:0] cap_addr_s;
  logic [AW-1:0] ref_addr_s;
  logic [IW-1:0] last_i_s;

  assign cap_addr_s = AW'(CAP_BASE) + AW'(i_q);
  assign ref_addr_s = AW'(REF_BASE) + AW'(i_q) + AW'(phase_q);
  assign last_i_s   = IW'(LEN - 1) - IW'(phase_q);

  sad_accumulator #(.DW(DW), .SW(SW)) u_acc (
    .clk    (CLK),
    .rst    (RST),
    .clear  (acc_clr_s),
    .enable (acc_en_s),
    .a      (a_q),
    .b      (b_q),
    .sum    (acc_sum_s)
  );

  // Next-state, counters, sample latches and best tracker.
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    phase_d      = phase_q;
    plim_d       = plim_q;
    wait_d       = wait_q;
    a_d          = a_q;
    b_d          = b_q;
    best_sum_d   = best_sum_q;
    best_phase_d = best_phase_q;
    addr_d       = addr_q;
    acc_clr_s    = 1'b0;
    acc_en_s     = 1'b0;
    if (ABORT && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            if (PHASE_LIMIT > PW'(MAX_PHASE)) begin
              plim_d = PW'(MAX_PHASE);
            end else begin
              plim_d = PHASE_LIMIT;
            end
            phase_d      = '0;
            i_d          = '0;
            acc_clr_s    = 1'b1;
            best_sum_d   = '1;
            best_phase_d = '0;
            state_d      = RD_CAP;
          end else begin
            state_d = IDLE;
          end
        end
        RD_CAP: begin
          addr_d  = cap_addr_s;
          wait_d  = '0;
          state_d = WAIT_CAP;
        end
        WAIT_CAP: begin
          if (wait_q == WW'(RD_LAT - 1)) begin
            a_d     = MEM_DATA;
            state_d = RD_REF;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        RD_REF: begin
          addr_d  = ref_addr_s;
          wait_d  = '0;
          state_d = WAIT_REF;
        end
        WAIT_REF: begin
          if (wait_q == WW'(RD_LAT - 1)) begin
            b_d     = MEM_DATA;
            state_d = ACC;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        ACC: begin
          acc_en_s = 1'b1;
          i_d      = i_q + IW'(1);
          if (i_q == last_i_s) begin
            state_d = EMIT;
          end else begin
            state_d = RD_CAP;
          end
        end
        EMIT: begin
          if (RES_READY) begin
            // Strict compare: on ties the earlier (lower) phase is kept.
            if (acc_sum_s < best_sum_q) begin
              best_sum_d   = acc_sum_s;
              best_phase_d = phase_q;
            end else begin
              best_sum_d   = best_sum_q;
            end
            if (phase_q == plim_q) begin
              state_d = FIN;
            end else begin
              phase_d   = phase_q + PW'(1);
              i_d       = '0;
              acc_clr_s = 1'b1;
              state_d   = RD_CAP;
            end
          end else begin
            state_d = EMIT;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      i_q          <= '0;
      phase_q      <= '0;
      plim_q       <= '0;
      wait_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
      best_sum_q   <= '0;
      best_phase_q <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      phase_q      <= phase_d;
      plim_q       <= plim_d;
      wait_q       <= wait_d;
      a_q          <= a_d;
      b_q          <= b_d;
      best_sum_q   <= best_sum_d;
      best_phase_q <= best_phase_d;
      addr_q       <= addr_d;
    end
  end

  // Output decode from registered state; address holds outside read states.
  always_comb begin
    MEM_RD   = 1'b0;
    MEM_ADDR = addr_q;
    case (state_q)
      RD_CAP: begin
        MEM_RD   = 1'b1;
        MEM_ADDR = cap_addr_s;
      end
      RD_REF: begin
        MEM_RD   = 1'b1;
        MEM_ADDR = ref_addr_s;
      end
      default: begin
        MEM_RD   = 1'b0;
        MEM_ADDR = addr_q;
      end
    endcase
  end

  assign RES_VALID  = (state_q == EMIT);
  assign RES_PHASE  = phase_q;
  assign RES_SUM    = acc_sum_s;
  assign BEST_PHASE = best_phase_q;
  assign BEST_SUM   = best_sum_q;
  assign BUSY       = (state_q != IDLE);
  assign DONE       = (state_q == FIN);

endmodule

// File: tb/tb_sad_phase_matcher.sv
// Scoreboard bench for sad_phase_matcher with a 1-cycle behavioural SRAM.
module tb_sad_phase_matcher;

  localparam int DW       = 16;
  localparam int AW       = 20;
  localparam int LEN      = 8;
  localparam int MAXP     = 3;
  localparam int RD_LAT   = 1;
  localparam int REF_BASE = 262144;
  localparam int SW       = 19;
  localparam int PW       = 2;

  logic          CLK = 1'b0;
  logic          RST, START, ABORT, RES_READY;
  logic [PW-1:0] PHASE_LIMIT;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_RD;
  logic [DW-1:0] MEM_DATA;
  logic          RES_VALID;
  logic [PW-1:0] RES_PHASE;
  logic [SW-1:0] RES_SUM;
  logic [PW-1:0] BEST_PHASE;
  logic [SW-1:0] BEST_SUM;
  logic          BUSY, DONE;

  typedef struct {
    int     phase;
    longint sum;
  } res_t;

  res_t   exp_q[$];
  int     cap_m[LEN];
  int     ref_m[LEN];
  longint exp_sum[MAXP+1];
  longint exp_best_sum;
  int     exp_best_phase;
  int     n_tests = 0;
  int     n_fail = 0;
  int     res_count = 0;
  bit     done_seen = 1'b0;
  int     cyc = 0;
  int     last_hs_cyc = 0;

  sad_phase_matcher #(
    .DW(DW), .AW(AW), .LEN(LEN), .MAX_PHASE(MAXP),
    .CAP_BASE(0), .REF_BASE(REF_BASE), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .PHASE_LIMIT(PHASE_LIMIT), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
    .MEM_DATA(MEM_DATA), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_PHASE(RES_PHASE), .RES_SUM(RES_SUM), .BEST_PHASE(BEST_PHASE),
    .BEST_SUM(BEST_SUM), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Cycle counter for latency measurements.
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural SRAM: data valid one cycle after the strobe.
  always @(posedge CLK) begin
    if (MEM_RD) begin
      if (int'(MEM_ADDR) < LEN) MEM_DATA <= DW'(cap_m[int'(MEM_ADDR)]);
      else if (int'(MEM_ADDR) >= REF_BASE && int'(MEM_ADDR) < REF_BASE + LEN)
        MEM_DATA <= DW'(ref_m[int'(MEM_ADDR) - REF_BASE]);
      else MEM_DATA <= 16'hDEAD;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on every handshake.
  always @(negedge CLK) begin
    res_t e;
    if (!RST && RES_VALID && RES_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_phase", 64'(RES_PHASE), 64'(e.phase));
        check("res_sum", 64'(RES_SUM), 64'(e.sum));
      end
      res_count++;
      last_hs_cyc = cyc;
    end
    if (!RST && DONE) begin
      check("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
      done_seen = 1'b1;
    end
  end

  // Reference model: expected per-phase sums and best tracker.
  task automatic push_expected(input int lim);
    int p_last;
    longint s;
    res_t r;
    p_last = (lim > MAXP) ? MAXP : lim;
    exp_best_sum = (64'd1 << SW) - 1;
    exp_best_phase = 0;
    for (int p = 0; p <= p_last; p++) begin
      s = 0;
      for (int i = 0; i <= LEN - 1 - p; i++) begin
        s += (cap_m[i] > ref_m[i+p]) ? cap_m[i] - ref_m[i+p] : ref_m[i+p] - cap_m[i];
      end
      exp_sum[p] = s;
      r.phase = p;
      r.sum = s;
      exp_q.push_back(r);
      if (s < exp_best_sum) begin
        exp_best_sum = s;
        exp_best_phase = p;
      end
    end
  endtask

  task automatic pulse_start(input logic [PW-1:0] lim);
    @(posedge CLK); #1;
    PHASE_LIMIT = lim;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_rd"}, 64'(MEM_RD), 64'd0);
    check({tag, "_mem_addr"}, 64'(MEM_ADDR), 64'd0);
    check({tag, "_res_valid"}, 64'(RES_VALID), 64'd0);
    check({tag, "_res_phase"}, 64'(RES_PHASE), 64'd0);
    check({tag, "_res_sum"}, 64'(RES_SUM), 64'd0);
    check({tag, "_best_phase"}, 64'(BEST_PHASE), 64'd0);
    check({tag, "_best_sum"}, 64'(BEST_SUM), 64'd0);
    check({tag, "_busy"}, 64'(BUSY), 64'd0);
    check({tag, "_done"}, 64'(DONE), 64'd0);
  endtask

  task automatic run_scan(input logic [PW-1:0] lim, input bit lat_chk, input bit bp, input bit restart);
    int  n;
    bit  ok;
    int  p_last;
    p_last = (int'(lim) > MAXP) ? MAXP : int'(lim);
    push_expected(int'(lim));
    res_count = 0;
    done_seen = 1'b0;
    pulse_start(lim);
    if (lat_chk) begin
      n = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge CLK);
        if (RES_VALID) break;
        if (BUSY) n++;
      end
      check("emit_latency", 64'(n), 64'(LEN * (2 * RD_LAT + 3)));
    end
    if (bp) begin
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge CLK);
        if (RES_VALID && RES_PHASE == 2'd0) begin ok = 1'b1; break; end
      end
      check("bp_phase0_seen", 64'(ok), 64'd1);
      @(posedge CLK); #1;
      RES_READY = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
        @(negedge CLK);
        if (RES_VALID) begin ok = 1'b1; break; end
      end
      check("bp_phase1_seen", 64'(ok), 64'd1);
      for (int k = 0; k < 20; k++) begin
        check("bp_valid", 64'(RES_VALID), 64'd1);
        check("bp_phase", 64'(RES_PHASE), 64'd1);
        check("bp_sum", 64'(RES_SUM), 64'(exp_sum[1]));
        check("bp_no_read", 64'(MEM_RD), 64'd0);
        @(negedge CLK);
      end
      @(posedge CLK); #1;
      RES_READY = 1'b1;
    end
    if (restart) begin
      repeat (10) @(posedge CLK);
      #1;
      PHASE_LIMIT = 2'd0;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge CLK);
      if (DONE) begin ok = 1'b1; break; end
    end
    check("done_reached", 64'(ok), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(res_count), 64'(p_last + 1));
    check("best_phase", 64'(BEST_PHASE), 64'(exp_best_phase));
    check("best_sum", 64'(BEST_SUM), 64'(exp_best_sum));
    @(negedge CLK);
    check("busy_after_fin", 64'(BUSY), 64'd0);
    check("done_one_cycle", 64'(DONE), 64'd0);
  endtask

  initial begin
    bit ok;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; RES_READY = 1'b1; PHASE_LIMIT = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check_zero("reset");

    // Identical records, single phase, with first-result latency.
    cap_m = '{10, 20, 30, 40, 50, 60, 70, 80};
    ref_m = '{10, 20, 30, 40, 50, 60, 70, 80};
    run_scan(2'd0, 1'b1, 1'b0, 1'b0);

    // Reference shifted by two samples: perfect match at phase 2.
    cap_m = '{5, 9, 2, 7, 1, 8, 3, 6};
    ref_m = '{0, 0, 5, 9, 2, 7, 1, 8};
    run_scan(2'd3, 1'b0, 1'b0, 1'b0);
    check("shift_best_phase", 64'(BEST_PHASE), 64'd2);

    // Single differing reference sample only contributes at phase 0.
    cap_m = '{100, 100, 100, 100, 100, 100, 100, 100};
    ref_m = '{0, 100, 100, 100, 100, 100, 100, 100};
    run_scan(2'd1, 1'b0, 1'b0, 1'b0);

    // All sums tie at zero: lowest phase must win.
    cap_m = '{77, 77, 77, 77, 77, 77, 77, 77};
    ref_m = '{77, 77, 77, 77, 77, 77, 77, 77};
    run_scan(2'd3, 1'b0, 1'b0, 1'b0);
    check("tie_best_phase", 64'(BEST_PHASE), 64'd0);

    // Backpressure at phase 1.
    cap_m = '{5, 9, 2, 7, 1, 8, 3, 6};
    ref_m = '{0, 0, 5, 9, 2, 7, 1, 8};
    run_scan(2'd3, 1'b0, 1'b1, 1'b0);

    // Largest limit the port can carry, plus START while busy.
    run_scan(2'd3, 1'b0, 1'b0, 1'b1);

    // Reset while waiting for reference data.
    pulse_start(2'd3);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (MEM_RD && int'(MEM_ADDR) >= REF_BASE) begin ok = 1'b1; break; end
    end
    check("rd_ref_seen", 64'(ok), 64'd1);
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check_zero("midscan_reset");
    exp_q.delete();

    // Abort during phase 1: back to idle, no DONE, best from phase 0 kept.
    push_expected(3);
    done_seen = 1'b0;
    pulse_start(2'd3);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (RES_VALID && RES_PHASE == 2'd0) begin ok = 1'b1; break; end
    end
    check("abort_phase0_seen", 64'(ok), 64'd1);
    repeat (3) @(posedge CLK);
    #1 ABORT = 1'b1;
    @(posedge CLK); #1 ABORT = 1'b0;
    @(negedge CLK);
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_valid", 64'(RES_VALID), 64'd0);
    check("abort_best_sum", 64'(BEST_SUM), 64'(exp_sum[0]));
    check("abort_best_phase", 64'(BEST_PHASE), 64'd0);
    repeat (60) @(negedge CLK);
    check("abort_no_done", 64'(done_seen), 64'd0);
    exp_q.delete();

    // Full scan after reset/abort recovery.
    run_scan(2'd3, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
